// File: rtl/systolic_pe_if.sv
// Operand/result bundle for one systolic PE.
// master drives operands in; slave is the PE side.
interface systolic_pe_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0]   top_in;
  logic [DATA_WIDTH-1:0]   left_in;
  logic [DATA_WIDTH-1:0]   right_out;
  logic [DATA_WIDTH-1:0]   bottom_out;
  logic [2*DATA_WIDTH-1:0] result;

  modport master (
    output top_in,
    output left_in,
    input  right_out,
    input  bottom_out,
    input  result
  );

  modport slave (
    input  top_in,
    input  left_in,
    output right_out,
    output bottom_out,
    output result
  );
endinterface

// File: rtl/systolic_pe.sv
// Output-stationary systolic PE: MAC into a local accumulator,
// operands forwarded right/down. Optional macro: PE_SATURATE_EN.
module systolic_pe #(
  parameter int DATA_WIDTH = 8
) (
  input logic         clk,
  input logic         rst_n,
  systolic_pe_if.slave pe
);
  localparam int AW = 2 * DATA_WIDTH;

  logic [AW-1:0] prod;
  logic [AW-1:0] acc_next;

`ifdef PE_SATURATE_EN
  logic [AW:0] sum;

  // one extra bit exposes overflow; clamp to all-ones
  always_comb begin
    prod     = AW'(pe.top_in) * AW'(pe.left_in);
    sum      = {1'b0, pe.result} + {1'b0, prod};
    acc_next = sum[AW] ? {AW{1'b1}} : sum[AW-1:0];
  end
`else
  // full-width product, sum wraps modulo 2^AW
  always_comb begin
    prod     = AW'(pe.top_in) * AW'(pe.left_in);
    acc_next = pe.result + prod;
  end
`endif

  // accumulate and forward every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe.result     <= '0;
      pe.right_out  <= '0;
      pe.bottom_out <= '0;
    end else begin
      pe.result     <= acc_next;
      pe.right_out  <= pe.left_in;
      pe.bottom_out <= pe.top_in;
    end
  end
endmodule

// File: tb/tb_systolic_pe.sv
// Self-checking bench for systolic_pe.
// Reference model uses plain integer arithmetic.
module tb_systolic_pe;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  longint exp_acc;
  int     exp_r;
  int     exp_b;

  systolic_pe_if #(.DATA_WIDTH(8)) bus ();

  systolic_pe #(.DATA_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pe    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".result"}, bus.result, 16'(exp_acc));
    check({tag, ".right"}, 16'(bus.right_out), 16'(exp_r));
    check({tag, ".bottom"}, 16'(bus.bottom_out), 16'(exp_b));
  endtask

  task automatic model_reset();
    exp_acc = 0;
    exp_r   = 0;
    exp_b   = 0;
  endtask

  task automatic cycle(input int t, input int l, input string tag);
    longint s;
    bus.top_in  = 8'(t);
    bus.left_in = 8'(l);
    @(posedge clk);
    #1;
    s = exp_acc + longint'(t) * longint'(l);
`ifdef PE_SATURATE_EN
    exp_acc = (s > 65535) ? 65535 : s;
`else
    exp_acc = s % 65536;
`endif
    exp_r = l;
    exp_b = t;
    check_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    int l;
    checks = 0;
    errors = 0;
    model_reset();

    rst_n       = 1'b0;
    bus.top_in  = 8'd9;
    bus.left_in = 8'd7;
    #1;
    check_all("rst0");
    repeat (2) begin
      @(posedge clk);
      #1;
      check_all("rst_hold");
    end
    rst_n = 1'b1;

    cycle(2, 3, "acc1");
    cycle(4, 5, "acc2");
    cycle(1, 10, "acc3");
    cycle(7, 2, "acc4");
    check("acc_total", bus.result, 16'd50);

    repeat (5) cycle(0, 0, "idle");
    check("idle_hold", bus.result, 16'd50);
    cycle(0, 200, "zero_top");
    cycle(150, 0, "zero_left");

    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("rst_async1");
    rst_n = 1'b1;
    cycle(255, 255, "ovf1");
    check("ovf1_val", bus.result, 16'd65025);
    cycle(255, 255, "ovf2");
`ifdef PE_SATURATE_EN
    check("ovf2_val", bus.result, 16'd65535);
    cycle(3, 3, "sat_stick");
`else
    check("ovf2_val", bus.result, 16'd64514);
`endif

    rst_n = 1'b0;
    model_reset();
    #1;
    rst_n = 1'b1;
    cycle(2, 3, "mid1");
    cycle(4, 5, "mid2");
    cycle(1, 10, "mid3");
    check("mid_36", bus.result, 16'd36);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("rst_mid");
    #1;
    rst_n = 1'b1;
    cycle(3, 3, "post_rst");
    check("post_rst_9", bus.result, 16'd9);

    rst_n = 1'b0;
    model_reset();
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: t = 0;
        1: t = 255;
        default: t = int'($urandom_range(0, 255));
      endcase
      case ($urandom_range(0, 3))
        0: l = 0;
        1: l = 255;
        default: l = int'($urandom_range(0, 255));
      endcase
      cycle(t, l, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/systolic_pe.md
Name: systolic_pe

Overview:
- Single processing element (PE) of an output-stationary systolic array for matrix multiplication.
- Each clock it multiplies the operand arriving from the top by the operand arriving from the left, and adds the product into a local accumulator.
- It forwards both operands, registered, to the right and bottom neighbours.
- Tiled N x N by the array wrapper: left_in/right_out chain horizontally, top_in/bottom_out chain vertically, and result is read per PE after the operand streams drain.

Parameters:
- DATA_WIDTH, 8, width of each operand and of each forwarded operand; the accumulator is 2*DATA_WIDTH bits.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- top_in  input  DATA_WIDTH  operand from the PE above (or the array edge).
- left_in  input  DATA_WIDTH  operand from the PE to the left (or the array edge).
- right_out  output  DATA_WIDTH  registered copy of left_in, to the right neighbour.
- bottom_out  output  DATA_WIDTH  registered copy of top_in, to the neighbour below.
- result  output  2*DATA_WIDTH  accumulator value.

Behaviour:
- Reset: rst_n low clears right_out, bottom_out and result to 0 immediately, with no clock required, and holds them at 0 while low.
- Reset mid-accumulation discards the partial sum. The first rising edge after rst_n rises performs a normal update.
- Each rising edge with rst_n high:
  - result <= result + top_in * left_in
  - right_out <= left_in
  - bottom_out <= top_in
- All three outputs are registers; no combinational path from inputs to outputs.
- Latency: one cycle. Operands present before edge k are reflected in result, right_out and bottom_out after edge k.
- Arithmetic: operands are unsigned. The product is a full 2*DATA_WIDTH-bit unsigned value.
- The sum is taken modulo 2^(2*DATA_WIDTH): accumulator overflow wraps, with no flag.
- There is no enable and no clear besides reset: the PE accumulates every cycle.
- Zero operands on either input leave result unchanged (idle/bubble cycles are encoded as 0).
- Forwarding is unconditional and independent of the accumulator; operand values pass through bit-exact.

Optional Feature:
- Macro PE_SATURATE_EN.
- When defined: the accumulation is computed one bit wider. If the true sum exceeds 2^(2*DATA_WIDTH)-1, result loads all-ones (65535 for DATA_WIDTH=8) and stays there until reset; further additions are ignored.
- When undefined: wrap-around as stated in Behaviour.
- Forwarding behaviour is identical in both builds.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with nonzero inputs -> result=0, right_out=0, bottom_out=0 throughout.
- Accumulate, with checks sampled one cycle after each input is applied:
  - (top,left)=(2,3) -> result=6
  - (4,5) -> 26
  - (1,10) -> 36
  - (7,2) -> 50
- Forwarding: in the same run -> right_out equals the previous cycle's left_in (3,5,10,2) and bottom_out equals the previous cycle's top_in (2,4,1,7).
- Idle: after the sequence drive 0/0 for 5 cycles -> result holds 50.
- Overflow: from reset apply (255,255) for 2 cycles -> result=65025 then 64514 (wrap). With PE_SATURATE_EN -> 65025 then 65535.
- Async reset mid-run: assert rst_n=0 between clock edges while result=36 -> all outputs 0 before the next edge. After release, (3,3) -> result=9.
